// File: rtl/sgb_pkg.sv
// Shared types and constants for the SGB joypad bridge: receiver states,
// MLT_REQ encodings, joypad select codes and button bit positions.
package sgb_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_WAIT_HI,
        RX_BIT,
        RX_STOP
    } rx_state_e;

    localparam logic [1:0] MLT_1P     = 2'd0;
    localparam logic [1:0] MLT_2P     = 2'd1;
    localparam logic [1:0] MLT_1P_ALT = 2'd2;
    localparam logic [1:0] MLT_4P     = 2'd3;

    // joy_p54 codes, active-low selects: [0]=P14, [1]=P15
    localparam logic [1:0] P54_BOTH = 2'b00;
    localparam logic [1:0] P54_BTN  = 2'b01;
    localparam logic [1:0] P54_DIR  = 2'b10;
    localparam logic [1:0] P54_NONE = 2'b11;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_START  = 7;

    function automatic logic [2:0] players(input logic [1:0] mlt);
        case (mlt)
            MLT_2P:  players = 3'd2;
            MLT_4P:  players = 3'd4;
            default: players = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/sgb_pkt_rx.sv
// SGB packet receiver: decodes the P14/P15 bit-bang protocol into a
// PKT_W-bit packet, shifting LSB-first into the top of the shift register.
module sgb_pkt_rx
    import sgb_pkg::*;
#(
    parameter int PKT_W = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [1:0]       p54,
    input  logic [1:0]       p54_prev,
    output logic [PKT_W-1:0] pkt_data,
    output logic             pkt_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(PKT_W + 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic [PKT_W-1:0] pkt_data_q, pkt_data_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic             busy_q, busy_d;

    // Decisions are taken only when the select lines differ from the
    // previous clk_en sample, so a held level is acted on exactly once.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = 1'b0;
        if (clk_en && (p54 != p54_prev)) begin
            case (state_q)
                RX_IDLE: begin
                    if (p54 == P54_BOTH) begin
                        state_d  = RX_SYNC;
                        bitcnt_d = '0;
                    end
                end
                RX_SYNC: begin
                    if (p54 == P54_NONE) state_d = RX_WAIT_HI;
                end
                RX_WAIT_HI: begin
                    case (p54)
                        P54_DIR, P54_BTN: begin
                            shift_d  = {(p54 == P54_BTN), shift_q[PKT_W-1:1]};
                            bitcnt_d = bitcnt_q + 1'b1;
                            state_d  = RX_BIT;
                        end
                        P54_BOTH: begin
                            state_d  = RX_SYNC;
                            bitcnt_d = '0;
                        end
                        default: ;
                    endcase
                end
                RX_BIT: begin
                    if (p54 == P54_NONE)
                        state_d = (bitcnt_q == CNT_W'(PKT_W)) ? RX_STOP : RX_WAIT_HI;
                end
                RX_STOP: begin
                    case (p54)
                        P54_DIR: begin
                            pkt_data_d  = shift_q;
                            pkt_valid_d = 1'b1;
                            state_d     = RX_IDLE;
                        end
                        P54_BTN: state_d = RX_IDLE;
                        P54_BOTH: begin
                            state_d  = RX_SYNC;
                            bitcnt_d = '0;
                        end
                        default: ;
                    endcase
                end
                default: state_d = RX_IDLE;
            endcase
        end
        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            bitcnt_q    <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Shift contents are fully overwritten before any packet can be latched.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign pkt_data  = pkt_data_q;
    assign pkt_valid = pkt_valid_q;
    assign busy      = busy_q;

endmodule

// File: rtl/sgb_joy_bridge.sv
// Bridge between the GB core joypad port and the SGB system: joypad mux with
// MLT_REQ player rotation, plus the command packet receiver.
module sgb_joy_bridge
    import sgb_pkg::*;
#(
    parameter  int NUM_PLAYERS = 4,
    parameter  int PKT_BYTES   = 16,
    localparam int PKT_W       = PKT_BYTES * 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic [1:0]               joy_p54,
    output logic [3:0]               joy_din,
    input  logic [8*NUM_PLAYERS-1:0] joy_btn,
    input  logic [1:0]               mlt_mode,
    output logic [PKT_W-1:0]         pkt_data,
    output logic                     pkt_valid,
    output logic                     pkt_busy,
    output logic [1:0]               player
);

    localparam logic [2:0] NP = 3'(NUM_PLAYERS);

    logic [1:0] p54_prev_q, p54_prev_d;
    logic [1:0] mlt_prev_q, mlt_prev_d;
    logic [1:0] player_q, player_d;
    logic [2:0] n_mode, n_eff, player_inc;
    logic [7:0] btn_sel;
    logic [3:0] dir_n, key_n;
    logic       rx_busy;

    sgb_pkt_rx #(
        .PKT_W(PKT_W)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .p54      (joy_p54),
        .p54_prev (p54_prev_q),
        .pkt_data (pkt_data),
        .pkt_valid(pkt_valid),
        .busy     (rx_busy)
    );

    always_comb begin
        n_mode     = players(mlt_mode);
        n_eff      = (n_mode < NP) ? n_mode : NP;
        player_inc = {1'b0, player_q} + 3'd1;
        p54_prev_d = p54_prev_q;
        mlt_prev_d = mlt_prev_q;
        player_d   = player_q;
        if (clk_en) begin
            p54_prev_d = joy_p54;
            mlt_prev_d = mlt_mode;
            // rx_busy reflects the receiver at the start of this clk_en.
            if (mlt_mode != mlt_prev_q)
                player_d = 2'd0;
            else if ((p54_prev_q == P54_BTN) && (joy_p54 == P54_NONE) && !rx_busy && (n_eff > 3'd1))
                player_d = (player_inc >= n_eff) ? 2'd0 : player_inc[1:0];
            else if ({1'b0, player_q} >= n_eff)
                player_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p54_prev_q <= P54_NONE;
            mlt_prev_q <= MLT_1P;
            player_q   <= 2'd0;
        end else begin
            p54_prev_q <= p54_prev_d;
            mlt_prev_q <= mlt_prev_d;
            player_q   <= player_d;
        end
    end

    // Only lanes that exist can be selected; player_q never reaches NUM_PLAYERS.
    always_comb begin
        btn_sel = 8'h00;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (player_q == 2'(i)) btn_sel = joy_btn[i*8 +: 8];
        end
        dir_n = ~{btn_sel[BTN_DOWN], btn_sel[BTN_UP], btn_sel[BTN_LEFT], btn_sel[BTN_RIGHT]};
        key_n = ~{btn_sel[BTN_START], btn_sel[BTN_SELECT], btn_sel[BTN_B], btn_sel[BTN_A]};
        case (joy_p54)
            P54_DIR:  joy_din = dir_n;
            P54_BTN:  joy_din = key_n;
            P54_BOTH: joy_din = dir_n & key_n;
            default:  joy_din = 4'hF - {2'b00, player_q};
        endcase
    end

    assign pkt_busy = rx_busy;
    assign player   = player_q;

endmodule
